uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx` byte transmitter between several byte-stream requesters: the command translator, distance/direction telemetry and IR echo. Whole multi-byte frames are never interleaved on the serial line. The block sits between the requesters and `uart_tx` and runs on the 50 MHz system clock. It arbitrates once per frame, holds the grant until the frame's last byte is accepted, and recovers from a requester that stalls mid-frame.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Frame-level arbiter sharing one uart_tx byte transmitter among NREQ requesters.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module uart_tx_arbiter #(
   parameter int NREQ    = 3,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic                     abort
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The counter is compared before its increment, so expiry fires as it would reach TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    g_q, g_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic                abort_q, abort_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    win_idx_s;
   logic                win_any_s;
   logic                g_valid_s, g_last_s, done_s, expire_s;

   assign g_valid_s = req_valid[g_q];
   assign g_last_s  = req_last[g_q];
   assign done_s    = (state_q == S_ACTIVE) & g_valid_s & tx_ready & g_last_s;

`ifdef UART_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_comb begin
      win_any_s = 1'b0;
      win_idx_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_any_s && req_valid[(int'(ptr_q) + i) % NREQ]) begin
            win_any_s = 1'b1;
            win_idx_s = IDX_W'((int'(ptr_q) + i) % NREQ);
         end else begin
            win_any_s = win_any_s;
         end
      end
   end

   always_comb begin
      if (state_q == S_IDLE && win_any_s) begin
         if (win_idx_s == IDX_W'(NREQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx_s + IDX_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      win_any_s = 1'b0;
      win_idx_s = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_any_s = 1'b1;
            win_idx_s = IDX_W'(i);
         end else begin
            win_any_s = win_any_s;
         end
      end
   end
`endif

   // Stall watchdog: counts ACTIVE cycles in which the granted requester has no byte.
   always_comb begin
      cnt_d    = cnt_q;
      expire_s = 1'b0;
      if (TIMEOUT == 0 || state_q != S_ACTIVE || g_valid_s) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         expire_s = 1'b1;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      case (state_q)
         S_IDLE:   state_d = win_any_s ? S_ACTIVE : S_IDLE;
         S_ACTIVE: state_d = (done_s || expire_s) ? S_IDLE : S_ACTIVE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if (state_q == S_IDLE && win_any_s) begin
         g_d = win_idx_s;
      end else begin
         g_d = g_q;
      end
      grant_d = '0;
      if (state_d == S_ACTIVE) begin
         grant_d[g_d] = 1'b1;
      end else begin
         grant_d = '0;
      end
      abort_d = expire_s;
   end

   // Outputs: tx side is a pure combinational pass-through of the granted requester.
   always_comb begin
      tx_data   = '0;
      tx_valid  = 1'b0;
      req_ready = '0;
      if (state_q == S_ACTIVE) begin
         tx_data        = req_data[int'(g_q)*DATA_W +: DATA_W];
         tx_valid       = g_valid_s;
         req_ready[g_q] = tx_ready & g_valid_s;
      end else begin
         tx_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         g_q     <= '0;
         grant_q <= '0;
         abort_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         g_q     <= g_d;
         grant_q <= grant_d;
         abort_q <= abort_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == S_ACTIVE);
   assign abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues feed the DUT,
// a scoreboard of expected serial bytes is checked at every transfer.
module tb_uart_tx_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 8;
   localparam int TMO  = 8;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NREQ*DW-1:0]    req_data;
   logic [NREQ-1:0]       req_valid, req_last, req_ready;
   logic [DW-1:0]         tx_data;
   logic                  tx_valid, tx_ready;
   logic [NREQ-1:0]       grant;
   logic                  busy, abort;

   typedef struct {int src; logic [7:0] data; logic last;} exp_t;
   typedef struct {logic [2:0] mask; logic [2:0] exp_grant;} vec_t;

   exp_t            sb[$];
   logic [8:0]      rq[NREQ][$];
   logic [NREQ-1:0] stall;
   logic [NREQ-1:0] acc;
   int              checks = 0;
   int              failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .abort(abort)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      logic [NREQ*DW-1:0] d;
      logic [NREQ-1:0]    v, l;
      d = '0; v = '0; l = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() != 0 && !stall[i]) begin
            v[i]         = 1'b1;
            d[i*DW +: DW] = rq[i][0][7:0];
            l[i]         = rq[i][0][8];
         end
      end
      req_data  = d;
      req_valid = v;
      req_last  = l;
   endtask

   task automatic push_frame(input int src, input int n, input logic [7:0] base, input bit exp_all);
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         logic       lst;
         b   = base + 8'(k);
         lst = (k == n - 1);
         rq[src].push_back({lst, b});
         if (exp_all) sb.push_back('{src, b, lst});
      end
   endtask

   // Mid-cycle monitor: any byte handed over at the next edge must match the scoreboard head.
   task automatic mon();
      exp_t e;
      acc = req_ready;
      if (tx_valid && tx_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer actual=%0h required=none at %0t", tx_data, $time);
         end else begin
            e = sb.pop_front();
            chk("xfer_data", tx_data, e.data);
            chk("xfer_grant", grant, 32'(1) << e.src);
            chk("xfer_ready", req_ready, 32'(1) << e.src);
         end
      end else if (tx_valid && !tx_ready && sb.size() != 0) begin
         chk("bp_data", tx_data, sb[0].data);
         chk("bp_ready", req_ready, 0);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      end
      drive();
   endtask

   task automatic flush();
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      sb.delete();
      stall = '0;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      tx_ready = 1'b1;
      flush();
      drive();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string name, input int bound);
      bit done;
      done = 1'b0;
      for (int n = 0; n < bound && !done; n++) begin
         done = (sb.size() == 0) && !busy && rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0;
         if (!done) tick();
      end
      chk(name, done, 1);
   endtask

   task automatic chk_zero_outputs(input string pfx);
      chk({pfx, "_grant"}, grant, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_abort"}, abort, 0);
      chk({pfx, "_tx_valid"}, tx_valid, 0);
      chk({pfx, "_req_ready"}, req_ready, 0);
      chk({pfx, "_tx_data"}, tx_data, 0);
   endtask

   initial begin
      vec_t vt[7];
      int   ord[6];
      int   fcnt[NREQ];

      vt[0] = '{3'b001, 3'b001};
      vt[1] = '{3'b010, 3'b010};
      vt[2] = '{3'b100, 3'b100};
      vt[3] = '{3'b011, 3'b001};
      vt[4] = '{3'b110, 3'b010};
      vt[5] = '{3'b101, 3'b001};
      vt[6] = '{3'b111, 3'b001};

      reset_n  = 1'b0;
      tx_ready = 1'b1;
      stall    = '0;
      drive();
      #2;
      chk_zero_outputs("reset");
      do_reset();

      // Arbitration table: 1-byte frames, winners served in ascending order after a reset.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         for (int i = 0; i < NREQ; i++) begin
            if (vt[v].mask[i]) push_frame(i, 1, 8'h50 + 8'(16 * i) + 8'(v), 1'b1);
         end
         drive();
         tick();
         chk("tbl_grant", grant, vt[v].exp_grant);
         chk("tbl_busy", busy, 1);
         drain("tbl_drain", 40);
      end

      // Single two-byte frame from requester 1.
      do_reset();
      push_frame(1, 2, 8'h44, 1'b0);
      rq[1][1] = {1'b1, 8'h32};
      sb.push_back('{1, 8'h44, 1'b0});
      sb.push_back('{1, 8'h32, 1'b1});
      drive();
      tick();
      chk("single_grant", grant, 3'b010);
      chk("single_busy1", busy, 1);
      tick();
      chk("single_busy2", busy, 1);
      tick();
      chk("single_busy_drop", busy, 0);
      chk("single_grant_clr", grant, 0);
      chk("single_sb_empty", sb.size(), 0);

      // Contention 0 vs 2: whole frame of 0, one idle cycle, then 2.
      do_reset();
      push_frame(0, 2, 8'h10, 1'b1);
      push_frame(2, 2, 8'h20, 1'b1);
      drive();
      tick();
      chk("cont_grant0", grant, 3'b001);
      tick();
      tick();
      chk("cont_gap_grant", grant, 0);
      chk("cont_gap_busy", busy, 0);
      tick();
      chk("cont_grant2", grant, 3'b100);
      drain("cont_drain", 20);

      // Continuous 1-byte frames from all three requesters.
`ifdef UART_ARB_ROUND_ROBIN_EN
      ord = '{0, 1, 2, 0, 1, 2};
`else
      ord = '{0, 0, 1, 1, 2, 2};
`endif
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         push_frame(i, 1, 8'h60 + 8'(16 * i), 1'b0);
         push_frame(i, 1, 8'h61 + 8'(16 * i), 1'b0);
         fcnt[i] = 0;
      end
      for (int k = 0; k < 6; k++) begin
         sb.push_back('{ord[k], 8'h60 + 8'(16 * ord[k]) + 8'(fcnt[ord[k]]), 1'b1});
         fcnt[ord[k]]++;
      end
      drive();
      drain("seq_drain", 60);

      // Backpressure for 50 cycles after the first byte.
      do_reset();
      push_frame(1, 3, 8'h70, 1'b1);
      drive();
      tick();
      tick();
      tx_ready = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("bp_abort", abort, 0);
         chk("bp_busy", busy, 1);
      end
      tx_ready = 1'b1;
      drain("bp_drain", 20);

      // Watchdog: requester 0 goes silent after byte 1 of 3.
      do_reset();
      push_frame(0, 3, 8'h80, 1'b0);
      sb.push_back('{0, 8'h80, 1'b0});
      push_frame(1, 1, 8'h90, 1'b1);
      drive();
      tick();
      chk("wd_grant0", grant, 3'b001);
      tick();
      stall[0] = 1'b1;
      drive();
      for (int k = 1; k < TMO; k++) begin
         tick();
         chk("wd_no_abort_early", abort, 0);
      end
      tick();
      chk("wd_abort", abort, 1);
      chk("wd_grant_clr", grant, 0);
      chk("wd_busy_clr", busy, 0);
      tick();
      chk("wd_abort_pulse", abort, 0);
      chk("wd_next_grant", grant, 3'b010);
      rq[0].delete();
      stall[0] = 1'b0;
      drive();
      drain("wd_drain", 20);

      // Reset during byte 2 of a frame, then pointer must be back at 0.
      do_reset();
      push_frame(1, 3, 8'hA0, 1'b0);
      sb.push_back('{1, 8'hA0, 1'b0});
      drive();
      tick();
      tick();
      chk("rst_mid_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero_outputs("rst_mid");
      flush();
      drive();
      tick();
      tick();
      reset_n = 1'b1;
      push_frame(0, 1, 8'hB0, 1'b1);
      push_frame(2, 1, 8'hB2, 1'b1);
      drive();
      tick();
      chk("rst_ptr_grant", grant, 3'b001);
      drain("rst_drain", 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
